// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Holds the FSM state enum, grant-owner enum and width defaults.
package dmem_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int LW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } state_t;

  typedef enum logic {
    CORE,
    HOST
  } owner_t;

endpackage

// File: rtl/dmem_burst_ctr.sv
// Host burst engine: latches base/len/we on load, counts beats.
// Ports: load/step controls, latched addr (wrapping), we, last flag.
module dmem_burst_ctr #(
  parameter int AW = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base_in,
  input  logic [LW-1:0] len_in,
  input  logic          we_in,
  output logic [AW-1:0] addr,
  output logic          we,
  output logic          last
);

  logic [AW-1:0] base_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt_q;
  logic          we_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
    end else if (load) begin
      base_q <= base_in;
      len_q  <= len_in;
      cnt_q  <= '0;
      we_q   <= we_in;
    end else if (step) begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // Sum is AW bits wide so the address wraps past the top.
  assign addr = base_q + AW'(cnt_q);
  assign we   = we_q;
  assign last = (cnt_q == len_q);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing dat_mem between core and host bursts.
// Ports: core req/stall, host burst req/beat/done, dat_mem bus.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdat,
  output logic [DW-1:0] core_rdat,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [LW-1:0] host_len,
  input  logic [DW-1:0] host_wdat,
  output logic          host_beat,
  output logic [DW-1:0] host_rdat,
  output logic          host_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdat
);

  state_t state_q, state_d;
  owner_t last_q, last_d;

  logic          load;
  logic          step;
  logic [AW-1:0] bc_addr;
  logic          bc_we;
  logic          bc_last;
  logic          core_win;
  logic          host_win;
  logic          we_c;
  logic          beat_c;
  logic          done_c;

  dmem_burst_ctr #(
    .AW (AW),
    .LW (LW)
  ) u_ctr (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .base_in (host_addr),
    .len_in  (host_len),
    .we_in   (host_we),
    .addr    (bc_addr),
    .we      (bc_we),
    .last    (bc_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= HOST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign core_win = core_req && !(host_req && last_q == CORE);
  assign host_win = host_req && (!core_req || last_q == CORE);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    load       = 1'b0;
    step       = 1'b0;
    mem_addr   = '0;
    mem_wdat   = '0;
    we_c       = 1'b0;
    beat_c     = 1'b0;
    done_c     = 1'b0;
    core_stall = core_req;
    unique case (state_q)
      IDLE: begin
        if (core_win) begin
          mem_addr   = core_addr;
          mem_wdat   = core_wdat;
          we_c       = core_we;
          core_stall = 1'b0;
          last_d     = CORE;
        end else if (host_win) begin
          load    = 1'b1;
          last_d  = HOST;
          state_d = BURST;
        end
      end
      BURST: begin
        mem_addr = bc_addr;
        mem_wdat = host_wdat;
        we_c     = bc_we;
        beat_c   = 1'b1;
        if (bc_last) state_d = DONE;
        else         step    = 1'b1;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate strobes so nothing reaches memory while reset is held.
  assign mem_we    = we_c & reset;
  assign host_beat = beat_c & reset;
  assign host_done = done_c & reset;
  assign core_rdat = mem_rdat;
  assign host_rdat = mem_rdat;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural dat_mem.
// Stimulus pushes expected accesses; a negedge monitor checks them.
module tb_dmem_arbiter;

  localparam int K_CORE = 0;
  localparam int K_HOST = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic       we;
    logic [7:0] dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdat, core_rdat;
  logic       core_stall;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdat, host_rdat;
  logic [3:0] host_len;
  logic       host_beat, host_done;
  logic [7:0] mem_addr, mem_wdat, mem_rdat;
  logic       mem_we;

  logic [7:0] mem [256];
  exp_t       sb [$];
  int         ntests = 0;
  int         nfail  = 0;

  dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdat  (core_wdat),
    .core_rdat  (core_rdat),
    .core_stall (core_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_len   (host_len),
    .host_wdat  (host_wdat),
    .host_beat  (host_beat),
    .host_rdat  (host_rdat),
    .host_done  (host_done),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdat   (mem_wdat),
    .mem_rdat   (mem_rdat)
  );

  always #5 clk = ~clk;

  assign mem_rdat = mem[mem_addr];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] = mem_wdat;
    end
  end

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  function automatic void push(int k, logic [7:0] a, logic w, logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.we   = w;
    e.dat  = d;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      automatic logic cg = core_req && !core_stall;
      automatic exp_t e;
      if (cg || host_beat) begin
        if (sb.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL unexp_access: addr %0h got access expected none", mem_addr);
        end else begin
          e = sb.pop_front();
          chk("acc_src", {31'd0, host_beat}, (e.kind == K_HOST) ? 1 : 0);
          chk("acc_addr", {24'd0, mem_addr}, {24'd0, e.addr});
          chk("acc_we", {31'd0, mem_we}, {31'd0, e.we});
          if (e.we)
            chk("acc_wdat", {24'd0, mem_wdat}, {24'd0, e.dat});
          else if (cg)
            chk("core_rdat", {24'd0, core_rdat}, {24'd0, e.dat});
          else
            chk("host_rdat", {24'd0, host_rdat}, {24'd0, e.dat});
        end
      end
      if (host_done) begin
        if (sb.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL unexp_done: got host_done expected none");
        end else begin
          e = sb.pop_front();
          chk("done_kind", e.kind, K_DONE);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single core access in an idle window.
  task automatic core_acc(logic w, logic [7:0] a, logic [7:0] d);
    core_req  = 1'b1;
    core_we   = w;
    core_addr = a;
    core_wdat = d;
    push(K_CORE, a, w, d);
    step();
    core_req = 1'b0;
  endtask

  logic [7:0] rd5 [6];
  bit         c4_req [10];
  bit         c4_stl [10];

  initial begin
    reset     = 1'b0;
    core_req  = 1'b1;
    core_we   = 1'b1;
    core_addr = 8'h10;
    core_wdat = 8'hA5;
    host_req  = 1'b0;
    host_we   = 1'b0;
    host_addr = 8'h00;
    host_len  = 4'd0;
    host_wdat = 8'h00;

    // Reset state: no strobes even with a core write pending.
    repeat (2) @(negedge clk);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_beat", {31'd0, host_beat}, 0);
    chk("rst_done", {31'd0, host_done}, 0);
    step();
    reset = 1'b1;

    // 1: core write then read back.
    push(K_CORE, 8'h10, 1'b1, 8'hA5);
    @(negedge clk);
    chk("t1_stall", {31'd0, core_stall}, 0);
    step();
    core_acc(1'b0, 8'h10, 8'hA5);
    step();

    // 2: host write burst 0x20..0x23 = 1..4.
    host_req  = 1'b1;
    host_we   = 1'b1;
    host_addr = 8'h20;
    host_len  = 4'd3;
    @(negedge clk);
    chk("t2_grant_beat", {31'd0, host_beat}, 0);
    step();
    host_addr = 8'h99;
    host_len  = 4'd0;
    host_we   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_wdat = 8'(i + 1);
      push(K_HOST, 8'h20 + 8'(i), 1'b1, 8'(i + 1));
      step();
    end
    host_req = 1'b0;
    push(K_DONE, 8'h00, 1'b0, 8'h00);
    step();
    for (int i = 0; i < 4; i++)
      core_acc(1'b0, 8'h20 + 8'(i), 8'(i + 1));
    step();

    // 3: wrapping read burst across 0xFF.
    core_acc(1'b1, 8'hFE, 8'h11);
    core_acc(1'b1, 8'hFF, 8'h22);
    core_acc(1'b1, 8'h00, 8'h33);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'hFE;
    host_len  = 4'd2;
    step();
    push(K_HOST, 8'hFE, 1'b0, 8'h11);
    step();
    push(K_HOST, 8'hFF, 1'b0, 8'h22);
    step();
    push(K_HOST, 8'h00, 1'b0, 8'h33);
    step();
    host_req = 1'b0;
    push(K_DONE, 8'h00, 1'b0, 8'h00);
    step();
    step();

    // 4: contention straight after reset.
    reset = 1'b0;
    step();
    reset = 1'b1;
    c4_req = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    c4_stl = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 8'h20;
    host_we   = 1'b0;
    host_addr = 8'h20;
    host_len  = 4'd1;
    for (int c = 0; c < 10; c++) begin
      host_req = c4_req[c];
      if (c == 0 || c == 5) push(K_CORE, 8'h20, 1'b0, 8'h01);
      if (c == 2 || c == 7) push(K_HOST, 8'h20, 1'b0, 8'h01);
      if (c == 3 || c == 8) push(K_HOST, 8'h21, 1'b0, 8'h02);
      if (c == 4 || c == 9) push(K_DONE, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      chk($sformatf("t4_stall_c%0d", c), {31'd0, core_stall}, {31'd0, c4_stl[c]});
      step();
    end
    core_req = 1'b0;
    step();

    // 5: host_req drops after beat 1; all six beats still run.
    rd5 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h7E, 8'h7F};
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h20;
    host_len  = 4'd5;
    step();
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) host_req = 1'b0;
      push(K_HOST, 8'h20 + 8'(i), 1'b0, rd5[i]);
      step();
    end
    push(K_DONE, 8'h00, 1'b0, 8'h00);
    step();
    step();

    // 6: reset during beat 2 of a write burst.
    host_req  = 1'b1;
    host_we   = 1'b1;
    host_addr = 8'h40;
    host_len  = 4'd3;
    step();
    host_wdat = 8'hB0;
    push(K_HOST, 8'h40, 1'b1, 8'hB0);
    step();
    host_wdat = 8'hB1;
    push(K_HOST, 8'h41, 1'b1, 8'hB1);
    step();
    host_wdat = 8'hB2;
    host_req  = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    chk("t6_rst_we", {31'd0, mem_we}, 0);
    chk("t6_rst_beat", {31'd0, host_beat}, 0);
    step();
    step();
    reset = 1'b1;
    repeat (3) step();
    core_acc(1'b0, 8'h40, 8'hB0);
    core_acc(1'b0, 8'h41, 8'hB1);
    core_acc(1'b0, 8'h42, 8'h18);
    core_acc(1'b0, 8'h43, 8'h19);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - the core load/store path, single-beat;
  - a host/DMA loader, multi-beat bursts used to preload operands and dump results.
- Sits between the core and `dat_mem`.
- Arbitrates round-robin at burst boundaries and stalls the core while a host burst owns memory.
- Memory read is combinational; memory write commits on the rising clock edge.

Parameters:
- AW, 8: memory address width.
- DW, 8: data width.
- LW, 4: burst length field width; a burst is host_len+1 beats, so 1..16.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- core_req  input  1  core memory access this cycle.
- core_we  input  1  core access is a write.
- core_addr  input  AW  core address.
- core_wdat  input  DW  core write data.
- core_rdat  output  DW  read data to core (mem_rdat passthrough).
- core_stall  output  1  core access not granted this cycle; core must hold PC and request.
- host_req  input  1  host burst request; held until host_done.
- host_we  input  1  burst is a write burst.
- host_addr  input  AW  burst start address.
- host_len  input  LW  beats minus one.
- host_wdat  input  DW  write data for the current beat.
- host_beat  output  1  current beat is executing; on a write, host_wdat is consumed; on a read, host_rdat is valid.
- host_rdat  output  DW  read data for the current beat.
- host_done  output  1  one-cycle pulse after the final beat.
- mem_addr  output  AW  to dat_mem addr.
- mem_we  output  1  to dat_mem wr_en.
- mem_wdat  output  DW  to dat_mem dat_in.
- mem_rdat  input  DW  from dat_mem dat_out.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last=HOST, beat counter=0, latched addr/len/we=0, host_done=0.
  - While reset is low, mem_we=0 and host_beat=0.
- States: IDLE, BURST, DONE.
- IDLE:
  - Core wins if core_req && !(host_req && last==CORE).
  - Host wins if host_req && (!core_req || last==CORE).
- Core grant (IDLE):
  - Combinational same cycle: mem_addr=core_addr, mem_we=core_we, mem_wdat=core_wdat, core_rdat=mem_rdat, core_stall=0.
  - Registered: last<=CORE.
  - Zero added latency.
- Host grant (IDLE):
  - core_stall=core_req.
  - No memory access this cycle.
  - Latch host_addr, host_len, host_we; counter<=0; last<=HOST.
  - Next state BURST.
- BURST:
  - Each cycle: mem_addr=latched_addr+counter, truncated to AW (wraps modulo 2^AW, e.g. 0xFF then 0x00).
  - mem_we=latched_we; mem_wdat=host_wdat; host_rdat=mem_rdat; host_beat=1.
  - core_stall=core_req.
  - When counter==latched_len, go to DONE; otherwise counter++.
- DONE:
  - host_done=1 for exactly one cycle; no memory access; core_stall=core_req.
  - Next state IDLE.
  - Host must drop host_req in the DONE cycle; host_req still high in IDLE is a new request.
- host_req deasserting mid-burst is ignored; the burst always completes all latched beats.
- host_addr/host_len/host_we changes after the grant cycle are ignored.
- Neither requester active in IDLE: mem_we=0, mem_addr=0, last unchanged.
- Reset asserted mid-burst: the burst is abandoned immediately and no further writes occur. Beats already written remain in memory.
- Fairness:
  - With both requesters continuously requesting, they alternate: one core access, then one full host burst.
  - Worst-case core stall is len+3 cycles: grant cycle, len+1 beats, DONE.

Decomposition:
- Shared package (dmem_pkg):
  - state enum typedef {IDLE, BURST, DONE};
  - grant owner enum {CORE, HOST};
  - default widths AW/DW/LW as localparams.
- One natural sub-module: dmem_burst_ctr, holding the latched base/len/we, beat counter, wrapped address generation and last-beat flag.
- Arbitration FSM and output muxing stay in dmem_arbiter.

Test Plan:
1. Core only: core_req=1, we=1, addr=0x10, wdat=0xA5 → mem_we=1 same cycle, core_stall=0. Next cycle read of 0x10 → core_rdat=0xA5.
2. Host write burst: host_addr=0x20, len=3, we=1, wdat sequence 1,2,3,4 → host_beat high 4 cycles at addresses 0x20..0x23. host_done pulses the cycle after; memory holds 1,2,3,4.
3. Wrap: host read burst, addr=0xFE, len=2 → mem_addr 0xFE, 0xFF, 0x00; host_rdat matches preloaded values.
4. Contention after reset: core_req=host_req=1 continuously → core granted first, then host burst; core_stall=1 for len+3 cycles, then core granted again.
5. Mid-burst drop: host_req falls after beat 1 of a len=5 burst → all 6 beats still execute and host_done pulses once.
6. Reset mid-burst: reset low during beat 2 of a write burst → mem_we=0 immediately; state IDLE; only beats 0–1 written; host_done never pulses.
